// File: rtl/mlp_conv_axi_mem_slave.sv
// mlp_conv_axi_mem_slave
//   AXI4-full memory-mapped slave backed by a 32-bit word memory. Independent write
//   (AW/W/B) and read (AR/R) engines, each with one outstanding burst. INCR and FIXED
//   bursts are supported; WRAP, reserved burst types, non-word sizes and bursts that
//   touch any address past the end of memory are fully handshaked but answered with
//   SLVERR and leave memory untouched.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESET   clock, synchronous active-high reset
//   S_AXI_AW*                   write address channel
//   S_AXI_W*                    write data channel
//   S_AXI_B*                    write response channel
//   S_AXI_AR*                   read address channel
//   S_AXI_R*                    read data channel
//   WR_DONE                     one-cycle pulse after a B handshake
//   RD_DONE                     one-cycle pulse after the last R handshake
module mlp_conv_axi_mem_slave #(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_MEM_DEPTH_WORDS  = 1024
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    // Write address
    input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic [2:0]                    S_AXI_AWSIZE,
    input  logic [1:0]                    S_AXI_AWBURST,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    // Write data
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    // Write response
    output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    // Read address
    input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [2:0]                    S_AXI_ARSIZE,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    // Read data
    output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    // Completion pulses
    output logic                          WR_DONE,
    output logic                          RD_DONE
);

    localparam int unsigned IdxW = $clog2(C_MEM_DEPTH_WORDS);
    localparam int unsigned AW   = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned IdW  = C_S_AXI_ID_WIDTH;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [AW:0] DepthWords = (AW + 1)'(C_MEM_DEPTH_WORDS);

    // A burst is rejected if its size/type is unsupported or its last beat lands past the
    // end of memory. The compare uses the full address plus a carry bit, so a burst can
    // never wrap back into range.
    function automatic logic burst_err(input logic [AW-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [AW:0] last_word;
        last_word = {1'b0, addr} >> 2;
        if (burst == BurstIncr) begin
            last_word = last_word + {{(AW - 7){1'b0}}, len};
        end
        return (size != 3'b010) || burst[1] || (last_word >= DepthWords);
    endfunction

    // ------------------------------------------------------------------------------------
    // Word memory: one byte-enabled write port, one registered read port
    // ------------------------------------------------------------------------------------
    logic [31:0]     mem_q [C_MEM_DEPTH_WORDS];
    logic            mem_we;
    logic [IdxW-1:0] mem_waddr;
    logic            mem_re;
    logic [IdxW-1:0] mem_raddr;
    logic [31:0]     rdata_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem_q[mem_waddr][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // Read data only advances when a new beat is needed, so RDATA cannot change under a
    // stall even if the write engine updates the same word. Same-cycle collisions read
    // the old value.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rdata_q <= '0;
        end else if (mem_re) begin
            rdata_q <= mem_q[mem_raddr];
        end
    end

    // ------------------------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------------------------
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

    w_state_e        w_state_q;
    logic            awready_q, wready_q, bvalid_q, wr_done_q;
    logic [IdW-1:0]  wid_q;
    logic [IdxW-1:0] widx_q;
    logic [7:0]      wlen_q, wbeat_q;
    logic            wfixed_q, waddr_err_q, wlast_err_q;
    logic [1:0]      bresp_q;
    logic            w_hs, w_is_last;

    assign w_hs      = S_AXI_WVALID && wready_q;
    assign w_is_last = (wbeat_q == wlen_q);
    // Only address/type errors suppress writes; a WLAST mismatch is reported in BRESP.
    assign mem_we    = (w_state_q == WData) && w_hs && !waddr_err_q;
    assign mem_waddr = widx_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state_q   <= WIdle;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            wr_done_q   <= 1'b0;
            wid_q       <= '0;
            widx_q      <= '0;
            wlen_q      <= '0;
            wbeat_q     <= '0;
            wfixed_q    <= 1'b0;
            waddr_err_q <= 1'b0;
            wlast_err_q <= 1'b0;
            bresp_q     <= RespOkay;
        end else begin
            wr_done_q <= 1'b0;
            case (w_state_q)
                WIdle: begin
                    awready_q <= 1'b1;
                    if (S_AXI_AWVALID && awready_q) begin
                        wid_q       <= S_AXI_AWID;
                        widx_q      <= S_AXI_AWADDR[2 +: IdxW];
                        wlen_q      <= S_AXI_AWLEN;
                        wbeat_q     <= '0;
                        wfixed_q    <= (S_AXI_AWBURST == BurstFixed);
                        waddr_err_q <= burst_err(S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE,
                                                 S_AXI_AWBURST);
                        wlast_err_q <= 1'b0;
                        awready_q   <= 1'b0;
                        wready_q    <= 1'b1;
                        w_state_q   <= WData;
                    end
                end
                WData: begin
                    if (w_hs) begin
                        wbeat_q <= wbeat_q + 8'd1;
                        if (!wfixed_q) begin
                            widx_q <= widx_q + IdxW'(1);
                        end
                        // The beat count alone ends the burst; WLAST only grades it.
                        if (w_is_last) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (waddr_err_q || wlast_err_q || !S_AXI_WLAST) ?
                                         RespSlvErr : RespOkay;
                            w_state_q <= WResp;
                        end else if (S_AXI_WLAST) begin
                            wlast_err_q <= 1'b1;
                        end
                    end
                end
                WResp: begin
                    if (S_AXI_BREADY && bvalid_q) begin
                        bvalid_q  <= 1'b0;
                        wr_done_q <= 1'b1;
                        awready_q <= 1'b1;
                        w_state_q <= WIdle;
                    end
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BID     = wid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign WR_DONE       = wr_done_q;

    // ------------------------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------------------------
    typedef enum logic {RIdle, RData} r_state_e;

    r_state_e        r_state_q;
    logic            arready_q, rvalid_q, rd_done_q;
    logic [IdW-1:0]  rid_q;
    logic [IdxW-1:0] ridx_q, ridx_next;
    logic [7:0]      rlen_q, rbeat_q;
    logic            rfixed_q, rerr_q;
    logic            r_hs;

    assign r_hs      = rvalid_q && S_AXI_RREADY;
    assign ridx_next = rfixed_q ? ridx_q : ridx_q + IdxW'(1);
    // Look ahead on a handshake so the next beat is ready on the following cycle.
    assign mem_raddr = r_hs ? ridx_next : ridx_q;
    assign mem_re    = (r_state_q == RData) && (!rvalid_q || r_hs);

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state_q <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rd_done_q <= 1'b0;
            rid_q     <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rfixed_q  <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            rd_done_q <= 1'b0;
            case (r_state_q)
                RIdle: begin
                    arready_q <= 1'b1;
                    if (S_AXI_ARVALID && arready_q) begin
                        rid_q     <= S_AXI_ARID;
                        ridx_q    <= S_AXI_ARADDR[2 +: IdxW];
                        rlen_q    <= S_AXI_ARLEN;
                        rbeat_q   <= '0;
                        rfixed_q  <= (S_AXI_ARBURST == BurstFixed);
                        rerr_q    <= burst_err(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE,
                                               S_AXI_ARBURST);
                        arready_q <= 1'b0;
                        r_state_q <= RData;
                    end
                end
                RData: begin
                    if (!rvalid_q) begin
                        rvalid_q <= 1'b1;
                    end else if (r_hs) begin
                        rbeat_q <= rbeat_q + 8'd1;
                        ridx_q  <= ridx_next;
                        if (rbeat_q == rlen_q) begin
                            rvalid_q  <= 1'b0;
                            rd_done_q <= 1'b1;
                            arready_q <= 1'b1;
                            r_state_q <= RIdle;
                        end
                    end
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RDATA   = rerr_q ? 32'h0 : rdata_q;
    assign S_AXI_RRESP   = rerr_q ? RespSlvErr : RespOkay;
    assign S_AXI_RLAST   = rvalid_q && (rbeat_q == rlen_q);
    assign RD_DONE       = rd_done_q;

endmodule
